// File: rtl/md5_cmd_pkg.sv
// Shared MD5 cracker command set: command codes, word counts, state types
// and the word selectors used by the host-side sequencer.
package md5_cmd_pkg;

    localparam logic [31:0] CMD_NOOP      = 32'h0000_0000;
    localparam logic [31:0] CMD_RESET_GEN = 32'h5230_0000;
    localparam logic [31:0] CMD_START     = 32'h5230_0001;
    localparam logic [31:0] CMD_SET_EXP_A = 32'h5230_1000;
    localparam logic [31:0] CMD_SET_EXP_B = 32'h5230_1001;
    localparam logic [31:0] CMD_SET_EXP_C = 32'h5230_1002;
    localparam logic [31:0] CMD_SET_EXP_D = 32'h5230_1003;
    localparam logic [31:0] CMD_SET_RANGE = 32'h5230_2000;
    localparam logic [31:0] CMD_COUNT_LO  = 32'h5230_3000;
    localparam logic [31:0] CMD_COUNT_HI  = 32'h5230_3001;
    localparam logic [31:0] CMD_TEXT1     = 32'h4400_0001;
    localparam logic [31:0] CMD_TEXT2     = 32'h4400_0002;
    localparam logic [31:0] CMD_TEXT3     = 32'h4400_0003;

    localparam logic [3:0] CFG_WORDS   = 4'd12;
    localparam logic [3:0] TEXT_WORDS  = 4'd3;
    localparam logic [3:0] COUNT_WORDS = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_WAIT_MATCH,
        ST_READ_TEXT,
        ST_READ_COUNT,
        ST_DONE,
        ST_ABORT
    } seq_state_t;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_SETUP,
        WS_HIGH,
        WS_LOW
    } ws_state_t;

    // Configuration word idx of a job: reset, four expected digest words, range, start.
    function automatic logic [31:0] config_word(input logic [3:0]   idx,
                                                input logic [127:0] hash,
                                                input logic [7:0]   mn,
                                                input logic [7:0]   mx);
        logic [31:0] w;
        case (idx)
            4'd0:    w = CMD_RESET_GEN;
            4'd1:    w = CMD_SET_EXP_A;
            4'd2:    w = hash[127:96];
            4'd3:    w = CMD_SET_EXP_B;
            4'd4:    w = hash[95:64];
            4'd5:    w = CMD_SET_EXP_C;
            4'd6:    w = hash[63:32];
            4'd7:    w = CMD_SET_EXP_D;
            4'd8:    w = hash[31:0];
            4'd9:    w = CMD_SET_RANGE;
            4'd10:   w = {16'h0000, mx, mn};
            4'd11:   w = CMD_START;
            default: w = CMD_NOOP;
        endcase
        return w;
    endfunction

    // Read-back command idx of the text phase (text_phase=1) or count phase.
    function automatic logic [31:0] read_word(input logic text_phase, input logic [3:0] idx);
        logic [31:0] w;
        if (text_phase) begin
            case (idx)
                4'd0:    w = CMD_TEXT1;
                4'd1:    w = CMD_TEXT2;
                4'd2:    w = CMD_TEXT3;
                default: w = CMD_NOOP;
            endcase
        end else begin
            case (idx)
                4'd0:    w = CMD_COUNT_LO;
                4'd1:    w = CMD_COUNT_HI;
                default: w = CMD_NOOP;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/md5_command_sequencer_if.sv
// Job/result and cracker command bus of the MD5 command sequencer.
interface md5_command_sequencer_if;

    logic         jobValid;
    logic         jobReady;
    logic [127:0] jobHash;
    logic [7:0]   jobMin;
    logic [7:0]   jobMax;
    logic         abort;
    logic [31:0]  cmdWord;
    logic         cmdStrobe;
    logic [31:0]  rspData;
    logic         matchIn;
    logic         resValid;
    logic         resReady;
    logic         resFound;
    logic [95:0]  resText;
    logic [63:0]  resCount;

    // Sequencer side
    modport slave (
        input  jobValid, jobHash, jobMin, jobMax, abort, rspData, matchIn, resReady,
        output jobReady, cmdWord, cmdStrobe, resValid, resFound, resText, resCount
    );

    // Host/cracker side
    modport master (
        output jobValid, jobHash, jobMin, jobMax, abort, rspData, matchIn, resReady,
        input  jobReady, cmdWord, cmdStrobe, resValid, resFound, resText, resCount
    );

endinterface

// File: rtl/md5_command_sequencer_word_strobe.sv
// One word transfer to the cracker: setup cycle, STROBE_CYCLES high,
// STROBE_CYCLES low; response captured on the last low cycle.
module md5_word_strobe
    import md5_cmd_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset2,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [31:0] rsp_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rsp,
    output logic [31:0] cmd_word,
    output logic        cmd_strobe
);

    localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    ws_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic             strobe_q, strobe_d;
    logic [31:0]      rsp_q, rsp_d;
    logic             last;

    assign last       = (cnt_q == CNT_LAST);
    // done marks the final low cycle; a new start is accepted in that same
    // cycle so consecutive words run back to back.
    assign done       = (state_q == WS_LOW) && last;
    assign busy       = (state_q != WS_IDLE) && !done;
    assign rsp        = rsp_q;
    assign cmd_word   = word_q;
    assign cmd_strobe = strobe_q;

    // Next-state and phase counter for the transfer timing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        strobe_d = strobe_q;
        rsp_d    = rsp_q;
        case (state_q)
            WS_IDLE: begin
                if (start) begin
                    state_d = WS_SETUP;
                    word_d  = word;
                end
            end
            WS_SETUP: begin
                state_d  = WS_HIGH;
                cnt_d    = '0;
                strobe_d = 1'b1;
            end
            WS_HIGH: begin
                if (last) begin
                    state_d  = WS_LOW;
                    cnt_d    = '0;
                    strobe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WS_LOW: begin
                if (last) begin
                    rsp_d = rsp_data;
                    cnt_d = '0;
                    if (start) begin
                        state_d = WS_SETUP;
                        word_d  = word;
                    end else begin
                        state_d = WS_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    // Transfer registers; reset drops the strobe at once.
    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            state_q  <= WS_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            strobe_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            strobe_q <= strobe_d;
            rsp_q    <= rsp_d;
        end
    end

endmodule

// File: rtl/md5_command_sequencer.sv
// Host-side job sequencer for the MD5 cracker: configures the target digest
// and range, waits for a match or timeout, reads back text and count.
module md5_command_sequencer
    import md5_cmd_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input logic                    clk,
    input logic                    reset2,
    md5_command_sequencer_if.slave bus
);

    seq_state_t   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [127:0] hash_q, hash_d;
    logic [7:0]   min_q, min_d;
    logic [7:0]   max_q, max_d;
    logic [1:0]   match_sync_q, match_sync_d;
    logic [31:0]  tmo_cnt_q, tmo_cnt_d;
    logic         found_q, found_d;
    logic [95:0]  text_q, text_d;
    logic [63:0]  count_q, count_d;
    logic         job_ready_q, job_ready_d;
    logic         res_valid_q, res_valid_d;
    logic         abort_sent_q, abort_sent_d;
    logic         rsp_vld_q, rsp_vld_d;
    logic [1:0]   wr_slot_q, wr_slot_d;
    logic         wr_text_q, wr_text_d;
    logic         wr_count_q, wr_count_d;

    logic         ws_start;
    logic [31:0]  ws_word;
    logic         ws_busy;
    logic         ws_done;
    logic [31:0]  ws_rsp;
    logic         phase_done;

    md5_word_strobe #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_word_strobe (
        .clk       (clk),
        .reset2    (reset2),
        .start     (ws_start),
        .word      (ws_word),
        .rsp_data  (bus.rspData),
        .busy      (ws_busy),
        .done      (ws_done),
        .rsp       (ws_rsp),
        .cmd_word  (bus.cmdWord),
        .cmd_strobe(bus.cmdStrobe)
    );

    // The captured response appears one cycle after done, so a phase ends
    // only once the last response has been written back (rsp_vld_q).
    assign phase_done = !ws_busy && rsp_vld_q;

    assign bus.jobReady = job_ready_q;
    assign bus.resValid = res_valid_q;
    assign bus.resFound = found_q;
    assign bus.resText  = text_q;
    assign bus.resCount = count_q;

    // Sequencer next-state, word issue and result write-back.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hash_d       = hash_q;
        min_d        = min_q;
        max_d        = max_q;
        match_sync_d = {match_sync_q[0], bus.matchIn};
        tmo_cnt_d    = tmo_cnt_q;
        found_d      = found_q;
        text_d       = text_q;
        count_d      = count_q;
        abort_sent_d = abort_sent_q;
        rsp_vld_d    = ws_done;
        wr_slot_d    = wr_slot_q;
        wr_text_d    = wr_text_q;
        wr_count_d   = wr_count_q;
        ws_start     = 1'b0;
        ws_word      = CMD_NOOP;

        if (ws_done) begin
            wr_slot_d  = 2'(idx_q - 4'd1);
            wr_text_d  = (state_q == ST_READ_TEXT);
            wr_count_d = (state_q == ST_READ_COUNT);
        end

        if (rsp_vld_q) begin
            if (wr_text_q) begin
                case (wr_slot_q)
                    2'd0:    text_d[31:0]  = ws_rsp;
                    2'd1:    text_d[63:32] = ws_rsp;
                    default: text_d[95:64] = ws_rsp;
                endcase
            end
            if (wr_count_q) begin
                if (wr_slot_q[0]) count_d[63:32] = ws_rsp;
                else              count_d[31:0]  = ws_rsp;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.jobValid && job_ready_q) begin
                    hash_d  = bus.jobHash;
                    min_d   = bus.jobMin;
                    max_d   = bus.jobMax;
                    found_d = 1'b0;
                    text_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    state_d = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                if (bus.abort) begin
                    state_d      = ST_ABORT;
                    abort_sent_d = 1'b0;
                end else if (idx_q < CFG_WORDS) begin
                    if (!ws_busy) begin
                        ws_start = 1'b1;
                        ws_word  = config_word(idx_q, hash_q, min_q, max_q);
                        idx_d    = idx_q + 4'd1;
                    end
                end else if (phase_done) begin
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_MATCH;
                end
            end
            ST_WAIT_MATCH: begin
                if (bus.abort) begin
                    state_d      = ST_ABORT;
                    abort_sent_d = 1'b0;
                end else if (match_sync_q[1]) begin
                    found_d = 1'b1;
                    idx_d   = '0;
                    state_d = ST_READ_TEXT;
                end else if (tmo_cnt_q >= TIMEOUT_CYCLES) begin
                    found_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_READ_COUNT;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            ST_READ_TEXT: begin
                if (bus.abort) begin
                    state_d      = ST_ABORT;
                    abort_sent_d = 1'b0;
                end else if (idx_q < TEXT_WORDS) begin
                    if (!ws_busy) begin
                        ws_start = 1'b1;
                        ws_word  = read_word(1'b1, idx_q);
                        idx_d    = idx_q + 4'd1;
                    end
                end else if (phase_done) begin
                    idx_d   = '0;
                    state_d = ST_READ_COUNT;
                end
            end
            ST_READ_COUNT: begin
                if (bus.abort) begin
                    state_d      = ST_ABORT;
                    abort_sent_d = 1'b0;
                end else if (idx_q < COUNT_WORDS) begin
                    if (!ws_busy) begin
                        ws_start = 1'b1;
                        ws_word  = read_word(1'b0, idx_q);
                        idx_d    = idx_q + 4'd1;
                    end
                end else if (phase_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.resReady) state_d = ST_IDLE;
            end
            ST_ABORT: begin
                // Let any in-flight word finish, then reset the generator.
                if (!abort_sent_q) begin
                    if (!ws_busy) begin
                        ws_start     = 1'b1;
                        ws_word      = CMD_RESET_GEN;
                        abort_sent_d = 1'b1;
                    end
                end else if (phase_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        job_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // Sequencer state, latched job, synchronizer and result registers.
    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            hash_q       <= '0;
            min_q        <= '0;
            max_q        <= '0;
            match_sync_q <= '0;
            tmo_cnt_q    <= '0;
            found_q      <= 1'b0;
            text_q       <= '0;
            count_q      <= '0;
            job_ready_q  <= 1'b1;
            res_valid_q  <= 1'b0;
            abort_sent_q <= 1'b0;
            rsp_vld_q    <= 1'b0;
            wr_slot_q    <= '0;
            wr_text_q    <= 1'b0;
            wr_count_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hash_q       <= hash_d;
            min_q        <= min_d;
            max_q        <= max_d;
            match_sync_q <= match_sync_d;
            tmo_cnt_q    <= tmo_cnt_d;
            found_q      <= found_d;
            text_q       <= text_d;
            count_q      <= count_d;
            job_ready_q  <= job_ready_d;
            res_valid_q  <= res_valid_d;
            abort_sent_q <= abort_sent_d;
            rsp_vld_q    <= rsp_vld_d;
            wr_slot_q    <= wr_slot_d;
            wr_text_q    <= wr_text_d;
            wr_count_q   <= wr_count_d;
        end
    end

endmodule

// File: doc/md5_command_sequencer.md
MD5_COMMAND_SEQUENCER -- requirements
Module: md5_command_sequencer

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 2, meaning cycles cmdStrobe is held high and then held low per word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd100_000_000, meaning clk cycles in WAIT_MATCH before giving up.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset2  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port jobValid  input  1  job request.
REQ-006 SHALL have port jobReady  output  1  sequencer idle and accepting a job.
REQ-007 SHALL have port jobHash  input  128  target digest {A,B,C,D}, A in [127:96].
REQ-008 SHALL have port jobMin, jobMax  input  8 each  character range.
REQ-009 SHALL have port abort  input  1  cancel the current job.
REQ-010 SHALL have port cmdWord  output  32  word presented to the cracker dataIn.
REQ-011 SHALL have port cmdStrobe  output  1  drives the cracker hasReceived; word sampled on its rising edge.
REQ-012 SHALL have port rspData  input  32  cracker dataOut.
REQ-013 SHALL have port matchIn  input  1  cracker hasMatched, asynchronous to this FSM.
REQ-014 SHALL have port resValid  output  1  result available.
REQ-015 SHALL have port resReady  input  1  result consumed.
REQ-016 SHALL have ports resFound (1, match seen), resText (96, {t3,t2,t1}), resCount (64, {hi,lo}), all outputs.

Function
REQ-017 Word transfer SHALL take 1 setup cycle, with cmdWord driven and cmdStrobe low, then STROBE_CYCLES high, then STROBE_CYCLES low; cmdWord SHALL be stable for the whole transfer.
REQ-018 rspData SHALL be captured on the last low cycle of a transfer; that capture is the response to the word just sent.
REQ-019 Command codes SHALL be: NoOp 0x00000000; ResetGen 0x52300000; Start 0x52300001; SetExpA–D 0x52301000–0x52301003; SetRange 0x52302000; CountLo 0x52303000; CountHi 0x52303001; Text1–3 0x44000001–0x44000003.
REQ-020 Job acceptance SHALL occur when jobValid and jobReady are high in the same cycle; inputs are latched that cycle and jobReady drops the next cycle.
REQ-021 States SHALL be IDLE, CONFIG, WAIT_MATCH, READ_TEXT, READ_COUNT, DONE, ABORT.
REQ-022 CONFIG SHALL send exactly 12 words in order: ResetGen, SetExpA, A, SetExpB, B, SetExpC, C, SetExpD, D, SetRange, {16'h0,max,min}, Start.
REQ-023 WAIT_MATCH SHALL pass matchIn through a 2-flop synchronizer and leave on synchronized match (found=1) or when the timeout counter reaches TIMEOUT_CYCLES (found=0). The counter is cleared on entry.
REQ-024 READ_TEXT SHALL send Text1, Text2, Text3 and store the responses into resText[31:0], [63:32], [95:64]; it SHALL be skipped when found=0, leaving resText = 0.
REQ-025 READ_COUNT SHALL send CountLo then CountHi and store the responses into resCount[31:0], [63:32].
REQ-026 DONE SHALL hold resValid high with stable result fields until resReady, then go to IDLE with resValid low the next cycle.
REQ-027 Match and timeout in the same cycle SHALL resolve as a match.
REQ-028 abort in CONFIG, WAIT_MATCH, READ_TEXT or READ_COUNT SHALL finish any in-flight word transfer, then send ResetGen, then return to IDLE with no result.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 Counters SHALL saturate, never wrap: the timeout counter is 32 bits, and the transfer-phase counter is sized for STROBE_CYCLES.

Reset
REQ-031 On reset2 the block SHALL enter IDLE with jobReady=1, cmdStrobe=0, cmdWord=0, resValid=0, resFound=0, resText=0, resCount=0, synchronizer flops and all counters 0.
REQ-032 reset2 asserted mid-transfer SHALL drop cmdStrobe immediately (asynchronously); no partial result SHALL be presented.

Structure
REQ-033 Command codes, the state enumeration and the word-count constants (12, 3, 2) SHALL live in shared package md5_cmd_pkg, for reuse by the cracker-side decoder.
REQ-034 The word-transfer timing of REQ-017/018 SHALL be sub-module md5_word_strobe, with start/busy/done handshake, word in, and captured response out.

Verification
REQ-035 Job hash 0x2971bc83_9b41f6a4_955620c0_9067fbfd, min 0x61, max 0x7a -> cmdWord sequence exactly per REQ-022, with word 11 = 0x00007a61 and 5 cycles per word at STROBE_CYCLES=2.
REQ-036 Responder model asserts matchIn 40 cycles after Start and answers Text1–3 with 0x64636261, 0x00000080, 0x0 and CountLo/Hi with 0x1234, 0x0 -> resFound=1, resText=0x00000000_00000080_64636261, resCount=0x1234.
REQ-037 TIMEOUT_CYCLES=100, matchIn never high -> no Text commands sent, resFound=0, resText=0, resCount from the responder.
REQ-038 abort pulsed at CONFIG word 5 -> word 5 completes, next word is 0x52300000, then IDLE with jobReady=1 and resValid never high.
REQ-039 resReady held low 20 cycles in DONE -> resValid and results stable for 20 cycles; a jobValid pulse during DONE is not accepted.
REQ-040 reset2 pulsed while cmdStrobe is high -> cmdStrobe=0 in the same cycle and all outputs at reset values per REQ-031.
